// File: rtl/uart_cmd_frame_rx.sv
// UART command-frame receiver: 8N1 byte receiver feeding a START/payload/checksum/STOP framer.
// Accepted payloads appear on cmd_data with a cmd_valid pulse. Abandoned frames pulse frame_err.
module uart_cmd_frame_rx #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter logic [7:0]  START_BYTE    = 8'h0A,
    parameter logic [7:0]  STOP_BYTE     = 8'h08,
    parameter int unsigned PAYLOAD_LEN   = 1,
    parameter int unsigned CHECKSUM_EN   = 0,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                     FCLK_CLK0_0,
    input  logic                     FCLK_RESET0_0,
    input  logic                     RxD,
    output logic [8*PAYLOAD_LEN-1:0] cmd_data,
    output logic                     cmd_valid,
    output logic                     frame_err,
    output logic [7:0]               err_cnt
);

    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned PL_W    = 8 * PAYLOAD_LEN;
    localparam int unsigned IDX_W   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int unsigned TO_CLKS = TIMEOUT_BYTES * 10 * DIV;
    localparam int unsigned TMR_W   = $clog2(TO_CLKS + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {F_IDLE, F_PAYLOAD, F_CHK, F_TRAIL} frm_state_e;

    // Synchroniser plus one history flop for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge FCLK_CLK0_0 or posedge FCLK_RESET0_0) begin
        if (FCLK_RESET0_0) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_q, byte_done_d;
    logic             byte_ok_q, byte_ok_d;
    logic [7:0]       byte_q, byte_d;

    always_ff @(posedge FCLK_CLK0_0 or posedge FCLK_RESET0_0) begin
        if (FCLK_RESET0_0) begin
            rx_state_q  <= RX_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            byte_ok_q   <= 1'b0;
            byte_q      <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            byte_ok_q   <= byte_ok_d;
            byte_q      <= byte_d;
        end
    end

    // Byte receiver: mid-bit sampling, counter reloads at every sample point
    always_comb begin
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        byte_ok_d   = byte_ok_q;
        byte_d      = byte_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = CNT_W'(HALF - 1);
                end
            end
            RX_START: begin
                if (bit_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = CNT_W'(DIV - 1);
                        bit_idx_d  = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bit_cnt_q == '0) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = CNT_W'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (bit_cnt_q == '0) begin
                    byte_done_d = 1'b1;
                    byte_ok_d   = rx_sync_q;
                    byte_d      = shift_q;
                    rx_state_d  = RX_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    frm_state_e       frm_state_q, frm_state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       acc_q, acc_d;
    logic [PL_W-1:0]  shadow_q, shadow_d;
    logic [PL_W-1:0]  cmd_data_q, cmd_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fail_c;

    always_ff @(posedge FCLK_CLK0_0 or posedge FCLK_RESET0_0) begin
        if (FCLK_RESET0_0) begin
            frm_state_q <= F_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            shadow_q    <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            tmr_q       <= '0;
        end else begin
            frm_state_q <= frm_state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            shadow_q    <= shadow_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            tmr_q       <= tmr_d;
        end
    end

    // Framer: one received byte or one timeout per cycle, so valid and error are exclusive
    always_comb begin
        frm_state_d = frm_state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        shadow_d    = shadow_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        tmr_d       = tmr_q;
        fail_c      = 1'b0;
        if (frm_state_q == F_IDLE) begin
            tmr_d = '0;
            if (byte_done_q && byte_ok_q && (byte_q == START_BYTE)) begin
                idx_d       = '0;
                acc_d       = '0;
                frm_state_d = F_PAYLOAD;
            end
        end else if (byte_done_q) begin
            tmr_d = '0;
            if (!byte_ok_q) begin
                fail_c = 1'b1;
            end else begin
                case (frm_state_q)
                    F_PAYLOAD: begin
                        for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
                            if (idx_q == IDX_W'(i)) shadow_d[8*i +: 8] = byte_q;
                        end
                        acc_d = acc_q ^ byte_q;
                        if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
                            frm_state_d = (CHECKSUM_EN != 0) ? F_CHK : F_TRAIL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    F_CHK: begin
                        if (byte_q == acc_q) frm_state_d = F_TRAIL;
                        else                 fail_c      = 1'b1;
                    end
                    F_TRAIL: begin
                        if (byte_q == STOP_BYTE) begin
                            cmd_data_d  = shadow_q;
                            cmd_valid_d = 1'b1;
                            frm_state_d = F_IDLE;
                        end else begin
                            fail_c = 1'b1;
                        end
                    end
                    default: fail_c = 1'b1;
                endcase
            end
        end else if (tmr_q == TMR_W'(TO_CLKS - 1)) begin
            fail_c = 1'b1;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (fail_c) begin
            frame_err_d = 1'b1;
            frm_state_d = F_IDLE;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Bench for uart_cmd_frame_rx: one default-baud instance plus two fast-baud instances
// (1-byte and 3-byte+checksum), driven by directed and random frames against a byte-level model.
module tb_uart_cmd_frame_rx;

    localparam int unsigned DIV_DEF   = 434;
    localparam int unsigned BAUD_FAST = 12500000;
    localparam int unsigned DIV_FAST  = 4;
    localparam int unsigned LONG_FAST = 4 * 10 * DIV_FAST + 3 * DIV_FAST;
    localparam logic [63:0] EV_ERR    = 64'hE000_0000_0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;

    wire logic [7:0]  data0, data1;
    wire logic [23:0] data2;
    wire logic [2:0]  vld, ferr;
    wire logic [7:0]  ecnt0, ecnt1, ecnt2;

    always #10 clk = ~clk;

    uart_cmd_frame_rx u_def (
        .FCLK_CLK0_0(clk), .FCLK_RESET0_0(rst), .RxD(rxd[0]),
        .cmd_data(data0), .cmd_valid(vld[0]), .frame_err(ferr[0]), .err_cnt(ecnt0));

    uart_cmd_frame_rx #(.BAUD(BAUD_FAST)) u_fast (
        .FCLK_CLK0_0(clk), .FCLK_RESET0_0(rst), .RxD(rxd[1]),
        .cmd_data(data1), .cmd_valid(vld[1]), .frame_err(ferr[1]), .err_cnt(ecnt1));

    uart_cmd_frame_rx #(.BAUD(BAUD_FAST), .PAYLOAD_LEN(3), .CHECKSUM_EN(1)) u_chk (
        .FCLK_CLK0_0(clk), .FCLK_RESET0_0(rst), .RxD(rxd[2]),
        .cmd_data(data2), .cmd_valid(vld[2]), .frame_err(ferr[2]), .err_cnt(ecnt2));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame model: position within frame, -1 while hunting for START
    int          pos[3];
    logic [7:0]  acc[3];
    logic [63:0] shadow[3];
    logic [63:0] m_data[3];
    int          m_err[3];
    logic [63:0] exp_q[3][$];
    logic [63:0] obs_q[3][$];

    function automatic int plen(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? DIV_DEF : DIV_FAST;
    endfunction

    function automatic logic [63:0] out_data(input int i);
        case (i)
            0:       return 64'(data0);
            1:       return 64'(data1);
            default: return 64'(data2);
        endcase
    endfunction

    function automatic logic [63:0] out_ecnt(input int i);
        case (i)
            0:       return 64'(ecnt0);
            1:       return 64'(ecnt1);
            default: return 64'(ecnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1; acc[i] = '0; shadow[i] = '0; m_data[i] = '0; m_err[i] = 0;
            exp_q[i].delete();
        end
    endtask

    task automatic model_fail(input int i);
        exp_q[i].push_back(EV_ERR);
        if (m_err[i] < 255) m_err[i]++;
        pos[i] = -1;
    endtask

    task automatic model_byte(input int i, input logic [7:0] b, input bit ok);
        if (pos[i] < 0) begin
            if (ok && b == 8'h0A) begin pos[i] = 0; acc[i] = '0; end
        end else if (!ok) begin
            model_fail(i);
        end else if (pos[i] < plen(i)) begin
            shadow[i][8*pos[i] +: 8] = b;
            acc[i] = acc[i] ^ b;
            pos[i]++;
        end else if (i == 2 && pos[i] == plen(i)) begin
            if (b == acc[i]) pos[i]++;
            else             model_fail(i);
        end else if (b == 8'h08) begin
            m_data[i] = shadow[i];
            exp_q[i].push_back(shadow[i]);
            pos[i] = -1;
        end else begin
            model_fail(i);
        end
    endtask

    // Record every output pulse as an event
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] || ferr[i]) begin
                check_eq($sformatf("excl%0d", i), 64'(vld[i] & ferr[i]), 64'd0);
                obs_q[i].push_back(ferr[i] ? EV_ERR : out_data(i));
            end
        end
    end

    task automatic send_byte(input int i, input logic [7:0] b, input bit ok);
        int unsigned d = div_of(i);
        rxd[i] = 1'b0;
        repeat (d) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd[i] = b[k];
            repeat (d) @(negedge clk);
        end
        rxd[i] = ok;
        repeat (d) @(negedge clk);
    endtask

    task automatic do_item(input int i, input logic [7:0] b, input bit ok, input int unsigned gap);
        send_byte(i, b, ok);
        model_byte(i, b, ok);
        rxd[i] = 1'b1;
        repeat (gap) @(negedge clk);
        if (gap >= 40 * div_of(i) && pos[i] >= 0) model_fail(i);
    endtask

    task automatic settle(input int i);
        rxd[i] = 1'b1;
        repeat (2 * div_of(i) + 10) @(negedge clk);
    endtask

    task automatic send_seq(input int i, input logic [63:0] bytes, input int n);
        for (int k = 0; k < n; k++) do_item(i, bytes[8*k +: 8], 1'b1, (i == 0) ? 50 : 2);
        settle(i);
    endtask

    task automatic compare_events(input int i);
        int n;
        check_eq($sformatf("ev_count%0d", i), 64'(obs_q[i].size()), 64'(exp_q[i].size()));
        n = (obs_q[i].size() < exp_q[i].size()) ? obs_q[i].size() : exp_q[i].size();
        for (int k = 0; k < n; k++) check_eq($sformatf("ev%0d_%0d", i, k), obs_q[i][k], exp_q[i][k]);
        check_eq($sformatf("err_cnt%0d", i), out_ecnt(i), 64'(m_err[i]));
        check_eq($sformatf("cmd_data%0d", i), out_data(i), m_data[i]);
        obs_q[i].delete();
        exp_q[i].delete();
    endtask

    task automatic rand_txn(input int i);
        logic [7:0] fr[$];
        logic [7:0] b, sum;
        int         mut, where;
        int unsigned gap;
        bit         ok;
        sum = '0;
        fr.push_back(8'h0A);
        for (int k = 0; k < plen(i); k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h08;
            fr.push_back(b);
            sum = sum ^ b;
        end
        if (i == 2) fr.push_back(sum);
        fr.push_back(8'h08);
        mut   = $urandom_range(0, 9);
        where = $urandom_range(0, fr.size() - 1);
        if (mut == 0) fr[where] = fr[where] ^ 8'($urandom_range(1, 255));
        if (mut == 3) fr.push_front(8'($urandom));
        if (mut == 4) void'(fr.pop_back());
        for (int k = 0; k < fr.size(); k++) begin
            ok  = !(mut == 1 && k == where);
            gap = (mut == 2 && k == where) ? LONG_FAST : $urandom_range(0, 2 * DIV_FAST);
            if (!ok && gap < DIV_FAST) gap = DIV_FAST;
            if (k == fr.size() - 1) gap = LONG_FAST;
            do_item(i, fr[k], ok, gap);
        end
        compare_events(i);
    endtask

    initial begin
        model_reset();
        repeat (5) @(negedge clk);
        check_eq("rst_data0", 64'(data0), 64'd0);
        check_eq("rst_data2", 64'(data2), 64'd0);
        check_eq("rst_vld", 64'(vld), 64'd0);
        check_eq("rst_ferr", 64'(ferr), 64'd0);
        check_eq("rst_ecnt1", 64'(ecnt1), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Default baud: one clean frame, then a short glitch
        send_seq(0, 64'h08_04_0A, 3);
        check_eq("def_valids", 64'(obs_q[0].size()), 64'd1);
        check_eq("def_data", 64'(data0), 64'h04);
        check_eq("def_ecnt", 64'(ecnt0), 64'd0);
        compare_events(0);
        rxd[0] = 1'b0;
        repeat (15) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (800) @(negedge clk);
        compare_events(0);

        // Bad trailer keeps data, next frame replaces it
        send_seq(1, 64'h08_04_0A, 3);
        compare_events(1);
        send_seq(1, 64'h07_04_0A, 3);
        check_eq("trail_ecnt", 64'(ecnt1), 64'd1);
        check_eq("trail_hold", 64'(data1), 64'h04);
        compare_events(1);
        send_seq(1, 64'h08_05_0A, 3);
        check_eq("next_data", 64'(data1), 64'h05);
        compare_events(1);

        // Checksum frames
        send_seq(2, 64'h08_3B_08_22_11_0A, 6);
        check_eq("chk_data", 64'(data2), 64'h082211);
        compare_events(2);
        send_seq(2, 64'h08_3C_08_22_11_0A, 6);
        check_eq("chk_bad_ecnt", 64'(ecnt2), 64'd1);
        check_eq("chk_bad_hold", 64'(data2), 64'h082211);
        compare_events(2);

        // Timeout after header, then junk before a frame
        do_item(1, 8'h0A, 1'b1, LONG_FAST);
        check_eq("tmo_ecnt", 64'(ecnt1), 64'd2);
        compare_events(1);
        send_seq(1, 64'h08_04_0A_55, 4);
        compare_events(1);

        // Trailer with framing error
        do_item(1, 8'h0A, 1'b1, 2);
        do_item(1, 8'h04, 1'b1, 2);
        do_item(1, 8'h08, 1'b0, DIV_FAST);
        settle(1);
        check_eq("stopbit_ecnt", 64'(ecnt1), 64'd3);
        compare_events(1);

        // Reset in the middle of the payload byte
        do_item(1, 8'h0A, 1'b1, 2);
        compare_events(1);
        rxd[1] = 1'b0;
        repeat (3 * DIV_FAST) @(negedge clk);
        rst = 1'b1;
        rxd[1] = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("midrst_pulses", 64'(obs_q[1].size()), 64'd0);
        check_eq("midrst_ecnt", 64'(ecnt1), 64'd0);
        check_eq("midrst_data", 64'(data1), 64'd0);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        send_seq(1, 64'h08_09_0A, 3);
        check_eq("postrst_data", 64'(data1), 64'h09);
        compare_events(1);

        for (int t = 0; t < 25; t++) rand_txn(1);
        for (int t = 0; t < 25; t++) rand_txn(2);

        // Saturate the error counter
        for (int t = 0; t < 256; t++) begin
            do_item(1, 8'h0A, 1'b1, 2);
            do_item(1, 8'($urandom), 1'b0, DIV_FAST);
        end
        settle(1);
        check_eq("sat_ecnt", 64'(ecnt1), 64'd255);
        compare_events(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
